// File: rtl/word_align_lock_param.sv
// Comma word aligner: searches a gated parallel stream for COMMA at any bit offset,
// then emits bit-aligned words and supervises the lock with an optional gap limit.
module word_align_lock_param #(
  parameter int unsigned    W                = 32,
  parameter logic [W-1:0]   COMMA            = 32'hDEADBEEF,
  parameter bit             MSB_FIRST        = 1'b0,
  parameter bit             VALID_ACTIVE_LOW = 1'b1,
  parameter int unsigned    LOSS_GAP         = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 din_valid,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic                 valid,
  output logic                 locked,
  output logic [$clog2(W)-1:0] offset,
  output logic                 comma_seen,
  output logic                 lock_lost
);

  localparam int unsigned OW = $clog2(W);
  localparam int unsigned CW = $clog2(LOSS_GAP + 2);

  typedef enum logic [1:0] {StIdle, StSearch, StLocked} state_e;

  state_e          r_state, w_state_d;
  logic [W-2:0]    r_hist, w_hist_d;
  logic [W-1:0]    r_dout, w_dout_d;
  logic            r_valid, w_valid_d;
  logic            r_comma, w_comma_d;
  logic            r_lost, w_lost_d;
  logic [OW-1:0]   r_idx, w_idx_d;
  logic [OW-1:0]   r_offset, w_offset_d;
  logic [CW-1:0]   r_gap, w_gap_d;

  logic            w_sample;
  logic [W-1:0]    w_din;
  logic [2*W-2:0]  w_cat;
  logic [W-1:0]    w_win;
  logic            w_found;
  logic [OW-1:0]   w_match;

  function automatic logic [W-1:0] f_rev(input logic [W-1:0] x);
    for (int k = 0; k < W; k++) f_rev[k] = x[W-1-k];
  endfunction

  assign w_sample = enable & (din_valid ^ VALID_ACTIVE_LOW);
  assign w_din    = MSB_FIRST ? f_rev(din) : din;
  // Index 0 is the earliest bit; the window ending at din[i] is w_cat[i +: W].
  assign w_cat    = {w_din, r_hist};
  assign w_win    = w_cat[r_idx +: W];

  always_comb begin
    w_found = 1'b0;
    w_match = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_cat[i +: W] == COMMA) begin
        w_found = 1'b1;
        w_match = OW'(i);
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_hist_d   = r_hist;
    w_dout_d   = r_dout;
    w_valid_d  = 1'b0;
    w_comma_d  = 1'b0;
    w_lost_d   = 1'b0;
    w_idx_d    = r_idx;
    w_offset_d = r_offset;
    w_gap_d    = r_gap;
    if (!enable) begin
      w_state_d = StIdle;
      w_hist_d  = '0;
      w_gap_d   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_state_d = StSearch;
        end
        StSearch: begin
          if (w_sample) begin
            w_hist_d = w_cat[2*W-2 -: W-1];
            if (w_found) begin
              w_state_d  = StLocked;
              w_idx_d    = w_match;
              w_offset_d = (w_match == OW'(W - 1)) ? '0 : w_match + 1'b1;
              w_gap_d    = '0;
            end
          end
        end
        StLocked: begin
          if (w_sample) begin
            w_hist_d = w_cat[2*W-2 -: W-1];
            if (w_win == COMMA) begin
              w_dout_d  = w_win;
              w_valid_d = 1'b1;
              w_comma_d = 1'b1;
              w_gap_d   = '0;
            end else if (LOSS_GAP != 0 && r_gap == CW'(LOSS_GAP)) begin
              // Gap budget exhausted: drop this word and restart the search clean.
              w_lost_d  = 1'b1;
              w_state_d = StSearch;
              w_hist_d  = '0;
              w_gap_d   = '0;
            end else begin
              w_dout_d  = w_win;
              w_valid_d = 1'b1;
              if (LOSS_GAP != 0) w_gap_d = r_gap + 1'b1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_hist   <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_comma  <= 1'b0;
      r_lost   <= 1'b0;
      r_idx    <= '0;
      r_offset <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_hist   <= w_hist_d;
      r_dout   <= w_dout_d;
      r_valid  <= w_valid_d;
      r_comma  <= w_comma_d;
      r_lost   <= w_lost_d;
      r_idx    <= w_idx_d;
      r_offset <= w_offset_d;
      r_gap    <= w_gap_d;
    end
  end

  assign dout       = MSB_FIRST ? f_rev(r_dout) : r_dout;
  assign valid      = r_valid;
  assign locked     = (r_state == StLocked);
  assign offset     = r_offset;
  assign comma_seen = r_comma;
  assign lock_lost  = r_lost;

endmodule

// File: tb/tb_word_align_lock_param.sv
// Bench for word_align_lock_param: three variants (plain, loss-gap 4, MSB-first) share
// stimulus; a per-variant queue holds expected aligned words.
module tb_word_align_lock_param;

  localparam logic [31:0] COMMA = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] w;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        din_valid;
  logic [31:0] din;
  logic [31:0] din_rev;

  logic [31:0] o_dout  [3];
  logic        o_valid [3];
  logic        o_locked[3];
  logic [4:0]  o_off   [3];
  logic        o_comma [3];
  logic        o_lost  [3];

  exp_t q[3][$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    for (int k = 0; k < 32; k++) rev32[k] = x[31-k];
  endfunction

  assign din_rev = rev32(din);

  always #5 clk = ~clk;

  word_align_lock_param #(.W(32), .COMMA(COMMA), .MSB_FIRST(1'b0), .VALID_ACTIVE_LOW(1'b1),
                          .LOSS_GAP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din_valid(din_valid), .din(din),
    .dout(o_dout[0]), .valid(o_valid[0]), .locked(o_locked[0]), .offset(o_off[0]),
    .comma_seen(o_comma[0]), .lock_lost(o_lost[0]));

  word_align_lock_param #(.W(32), .COMMA(COMMA), .MSB_FIRST(1'b0), .VALID_ACTIVE_LOW(1'b1),
                          .LOSS_GAP(4)) u_gap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din_valid(din_valid), .din(din),
    .dout(o_dout[1]), .valid(o_valid[1]), .locked(o_locked[1]), .offset(o_off[1]),
    .comma_seen(o_comma[1]), .lock_lost(o_lost[1]));

  word_align_lock_param #(.W(32), .COMMA(COMMA), .MSB_FIRST(1'b1), .VALID_ACTIVE_LOW(1'b1),
                          .LOSS_GAP(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din_valid(din_valid), .din(din_rev),
    .dout(o_dout[2]), .valid(o_valid[2]), .locked(o_locked[2]), .offset(o_off[2]),
    .comma_seen(o_comma[2]), .lock_lost(o_lost[2]));

  // Scoreboard: every valid pops one expected word; stray valids or comma pulses fail.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (o_valid[k]) begin
        exp_t e;
        checks++;
        if (q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid dut%0d: dout=%h, no word expected", k, o_dout[k]);
        end else begin
          e = q[k].pop_front();
          if (o_dout[k] !== e.w) begin
            errors++;
            $display("FAIL dout dut%0d: got %h, expected %h", k, o_dout[k], e.w);
          end
          checks++;
          if (o_comma[k] !== e.c) begin
            errors++;
            $display("FAIL comma_seen dut%0d: got %b, expected %b", k, o_comma[k], e.c);
          end
        end
      end else if (o_comma[k] !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL comma_without_valid dut%0d: got %b, expected 0", k, o_comma[k]);
      end
    end
  end

  task automatic expect_word(input logic [31:0] w, input logic [2:0] mask);
    exp_t e;
    e.c = (w == COMMA);
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        e.w = (k == 2) ? rev32(w) : w;
        q[k].push_back(e);
      end
    end
  endtask

  // One sample (din_valid low), then `gaps` non-sample cycles carrying junk data.
  task automatic sample(input logic [31:0] w, input int gaps);
    @(negedge clk);
    din       = w;
    din_valid = 1'b0;
    @(negedge clk);
    din_valid = 1'b1;
    din       = $urandom;
    repeat (gaps) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_dout[k] !== 32'h0 || o_valid[k] !== 1'b0 || o_locked[k] !== 1'b0 ||
          o_off[k] !== 5'd0 || o_comma[k] !== 1'b0 || o_lost[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: dout=%h v=%b l=%b off=%0d c=%b ll=%b, expected all 0",
                 k, o_dout[k], o_valid[k], o_locked[k], o_off[k], o_comma[k], o_lost[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    do_reset();
    sample(COMMA, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_locked[k] !== 1'b1 || o_off[k] !== 5'd0) begin
        errors++;
        $display("FAIL aligned_lock dut%0d: locked=%b offset=%0d, expected 1 and 0",
                 k, o_locked[k], o_off[k]);
      end
    end
    expect_word(32'h12345678, 3'b111);
    sample(32'h12345678, 0);
    expect_word(32'hCAFEF00D, 3'b111);
    sample(32'hCAFEF00D, 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL aligned_drain dut%0d: %0d words missing, expected 0", k, q[k].size());
      end
    end
  endtask

  task automatic test_offset(input int gaps);
    do_reset();
    sample(32'hADBEEF00, gaps);
    checks++;
    if (o_locked[0] !== 1'b0) begin
      errors++;
      $display("FAIL early_lock gaps=%0d: locked=%b, expected 0", gaps, o_locked[0]);
    end
    sample(32'hA5A5A5DE, gaps);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_locked[k] !== 1'b1 || o_off[k] !== 5'd8) begin
        errors++;
        $display("FAIL offset8_lock dut%0d gaps=%0d: locked=%b offset=%0d, expected 1 and 8",
                 k, gaps, o_locked[k], o_off[k]);
      end
    end
    expect_word(32'hA5A5A5A5, 3'b111);
    sample(32'h000000A5, gaps);
    expect_word(32'h3C000000, 3'b111);
    sample(32'h0000003C, gaps);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL offset8_drain dut%0d gaps=%0d: %0d words missing, expected 0",
                 k, gaps, q[k].size());
      end
    end
  endtask

  task automatic test_loss();
    logic [31:0] w;
    do_reset();
    sample(COMMA, 0);
    for (int n = 1; n <= 5; n++) begin
      w = 32'h11111111 * n;
      expect_word(w, (n <= 4) ? 3'b111 : 3'b101);
      sample(w, 0);
    end
    checks++;
    if (o_lost[1] !== 1'b1 || o_locked[1] !== 1'b0) begin
      errors++;
      $display("FAIL loss_pulse: lock_lost=%b locked=%b, expected 1 and 0", o_lost[1], o_locked[1]);
    end
    checks++;
    if (o_locked[0] !== 1'b1 || o_lost[0] !== 1'b0) begin
      errors++;
      $display("FAIL no_loss_gap0: locked=%b lock_lost=%b, expected 1 and 0",
               o_locked[0], o_lost[0]);
    end
    @(negedge clk);
    checks++;
    if (o_lost[1] !== 1'b0) begin
      errors++;
      $display("FAIL loss_pulse_width: lock_lost=%b, expected 0", o_lost[1]);
    end

    do_reset();
    sample(COMMA, 0);
    for (int n = 1; n <= 7; n++) begin
      w = (n == 5) ? COMMA : 32'h01010101 * n;
      expect_word(w, 3'b111);
      sample(w, 0);
      checks++;
      if (o_locked[1] !== 1'b1 || o_lost[1] !== 1'b0) begin
        errors++;
        $display("FAIL comma_refresh word%0d: locked=%b lock_lost=%b, expected 1 and 0",
                 n, o_locked[1], o_lost[1]);
      end
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL loss_drain dut%0d: %0d words missing, expected 0", k, q[k].size());
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    sample(COMMA, 0);
    expect_word(32'h0BADC0DE, 3'b111);
    sample(32'h0BADC0DE, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_dout[k] !== 32'h0 || o_valid[k] !== 1'b0 || o_locked[k] !== 1'b0 ||
          o_off[k] !== 5'd0 || o_comma[k] !== 1'b0 || o_lost[k] !== 1'b0) begin
        errors++;
        $display("FAIL midlock_reset dut%0d: dout=%h v=%b l=%b off=%0d, expected all 0",
                 k, o_dout[k], o_valid[k], o_locked[k], o_off[k]);
      end
    end
    @(negedge clk);
    sample(COMMA, 0);
    checks++;
    if (o_locked[0] !== 1'b1 || o_off[0] !== 5'd0) begin
      errors++;
      $display("FAIL relock: locked=%b offset=%0d, expected 1 and 0", o_locked[0], o_off[0]);
    end
    expect_word(32'h76543210, 3'b111);
    sample(32'h76543210, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0) begin
      errors++;
      $display("FAIL relock_drain: %0d/%0d/%0d words missing, expected 0",
               q[0].size(), q[1].size(), q[2].size());
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    sample(32'hADBEEF00, 0);
    sample(32'hA5A5A5DE, 0);
    @(negedge clk);
    enable    = 1'b0;
    din       = 32'h000000A5;
    din_valid = 1'b0;
    @(negedge clk);
    din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_locked[k] !== 1'b0 || o_lost[k] !== 1'b0 || o_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL enable_drop dut%0d: locked=%b lock_lost=%b valid=%b, expected 0/0/0",
                 k, o_locked[k], o_lost[k], o_valid[k]);
      end
    end
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    din_valid = 1'b1;
    din       = 32'h0;
    test_reset();
    test_aligned();
    test_offset(0);
    test_offset(3);
    test_loss();
    test_reset_mid_lock();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/word_align_lock_param.md
Name: word_align_lock_param

Overview:
Parametrised successor of the fixed 32-bit comma word aligner. It consumes a gated parallel word stream and finds a programmable comma pattern at any bit offset. It emits bit-aligned words and reports the lock offset. After lock it supervises the stream for loss of alignment and returns to search autonomously. It sits between the deserialiser model and frame checkers in the TB common modules.

Parameters:
W, 32, word and comma width (8..64)
COMMA, 32'hDEADBEEF (W bits), alignment pattern
MSB_FIRST, 0, 0: din[0] is earliest bit in time; 1: din[W-1] is earliest
VALID_ACTIVE_LOW, 1, polarity of din_valid (1: low = sample)
LOSS_GAP, 0, aligned words allowed without an aligned comma before lock loss; 0 = never lose lock

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  block enable; low forces IDLE
din_valid  in  1  sample strobe, polarity per VALID_ACTIVE_LOW
din  in  W  parallel input word
dout  out  W  aligned word, same bit order as din
valid  out  1  1-cycle pulse, dout valid
locked  out  1  high in LOCKED
offset  out  $clog2(W)  first payload bit index within input word, held while locked
comma_seen  out  1  1-cycle pulse with valid when dout==COMMA
lock_lost  out  1  1-cycle pulse on LOCKED->SEARCH

Behaviour:
- Reset (rst_n low at a clk edge, also mid-operation): state IDLE, history cleared. Outputs dout=0, valid=0, locked=0, offset=0, comma_seen=0, lock_lost=0. Reset has priority over enable.
- Serial model: if MSB_FIRST=1, reverse din on entry and dout on exit. Internally, stream bit n*W+k is din[k] of sample n. COMMA[0] is the earliest comma bit.
- A sample is a cycle with enable=1 and din_valid asserted. Cycles without a sample change nothing except clearing the pulse outputs.
- States:
  - IDLE: entered on enable=0. Clears history and gap counter. Goes to SEARCH on enable=1.
  - SEARCH: keeps a W-1 bit history. On each sample, tests all W end positions i=0..W-1 in time order, using history plus din[0..i]. The earliest match wins. Later matches in the same word are ignored.
  - On a match at index i: offset<=(i+1)%W, locked<=1, go to LOCKED.
  - LOCKED: assembles words starting at the stream bit immediately after the comma.
- Output timing: dout/valid are registered. valid pulses in the cycle after the sample that supplies the last bit of an aligned word.
  - offset=0: the first aligned word is the next sample.
  - offset=o>0: the aligned word is din[W-1:o] of sample n+1 (low part) and din[o-1:0] of sample n+2 (high part).
  - No payload bits from the comma word are ever output. There is exactly one valid per sample thereafter.
- Lock supervision (LOSS_GAP>0):
  - A gap counter is cleared when an aligned word equals COMMA and comma_seen pulses.
  - The counter increments on every other aligned word.
  - When the counter would exceed LOSS_GAP: lock_lost pulses, locked<=0, state goes to SEARCH with history cleared, and the valid for that word is suppressed.
  - A comma at a non-aligned offset while locked is ignored.
- enable falling while LOCKED: locked drops next edge. No lock_lost pulse and no further valid.
- Counter width is $clog2(LOSS_GAP+2). It saturates and never wraps.

Test Plan:
- Aligned comma (W=32, LSB first): samples DEADBEEF, 12345678 -> locked=1 and offset=0 the cycle after the first sample; dout=12345678, valid=1 the cycle after the second sample.
- Offset 8: samples ADBEEF00, A5A5A5DE, 000000A5 -> offset=8; single valid with dout=A5A5A5A5 the cycle after the third sample.
- Gated input: repeat the offset-8 case with din_valid deasserted for 3 cycles between samples -> identical dout sequence, valid only after real samples.
- Loss: LOSS_GAP=4, lock at offset 0, then 5 aligned non-comma words -> 4 valid pulses, lock_lost pulse on the 5th, locked=0. Reinserting an aligned DEADBEEF before the 5th -> comma_seen pulse, lock held.
- MSB_FIRST=1: bit-reversed offset-8 stimulus -> offset=8 and dout = bit-reverse of A5A5A5A5.
- Reset mid-lock: assert rst_n=0 for 1 cycle while LOCKED -> all outputs 0 next edge; a new comma re-locks normally.
